mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_if.sv | 21 ++
 rtl/mem_access_ctrl.sv | 123 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Requester-side handshake bundle for mem_access_ctrl.
// master: the requesting agent; slave: the controller.
interface mem_access_ctrl_if;
    logic        REQ;
    logic        REQ_WE;
    logic [25:0] REQ_ADDR;
    logic [31:0] REQ_WDATA;
    logic        ACK;
    logic [31:0] RDATA;
    logic        BUSY;

    modport master (
        output REQ, REQ_WE, REQ_ADDR, REQ_WDATA,
        input  ACK, RDATA, BUSY
    );

    modport slave (
        input  REQ, REQ_WE, REQ_ADDR, REQ_WDATA,
        output ACK, RDATA, BUSY
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding memory access controller.
// Accepts one read or write request in IDLE, runs the memory strobe
// sequence (read waits RD_WAIT extra cycles before capture), then spends
// one ACK cycle with both strobes low as bus turnaround.
// Optional macro MEM_ACC_STATS_EN enables saturating completed read/write
// counters on RD_CNT/WR_CNT; without it both ports are tied to zero.
module mem_access_ctrl #(
    parameter int unsigned RD_WAIT = 1
) (
    input  logic              CLK,
    input  logic              RST,
    mem_access_ctrl_if.slave  req_bus,
    output logic              READ,
    output logic              WRITE,
    output logic [25:0]       ADDR,
    inout  wire  [31:0]       DATA,
    output logic [15:0]       RD_CNT,
    output logic [15:0]       WR_CNT
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_ACK
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT);

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [25:0] addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        capture;

    // Next-state and latch decisions; request inputs only matter in IDLE
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        addr_d  = ADDR;
        wdata_d = wdata_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_bus.REQ) begin
                    addr_d  = req_bus.REQ_ADDR;
                    wdata_d = req_bus.REQ_WDATA;
                    wait_d  = '0;
                    state_d = req_bus.REQ_WE ? S_WR : S_RD;
                end
            end
            S_RD: begin
                if (wait_q == WAIT_LAST) begin
                    capture = 1'b1;
                    state_d = S_ACK;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_WR:    state_d = S_ACK;
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and read-wait counter register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Outputs are registered from the upcoming state so strobes align with it
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            READ          <= 1'b0;
            WRITE         <= 1'b0;
            ADDR          <= '0;
            wdata_q       <= '0;
            req_bus.ACK   <= 1'b0;
            req_bus.BUSY  <= 1'b0;
            req_bus.RDATA <= '0;
        end else begin
            READ         <= (state_d == S_RD);
            WRITE        <= (state_d == S_WR);
            req_bus.ACK  <= (state_d == S_ACK);
            req_bus.BUSY <= (state_d != S_IDLE);
            ADDR         <= addr_d;
            wdata_q      <= wdata_d;
            if (capture) begin
                req_bus.RDATA <= DATA;
            end
        end
    end

    // Bus is driven only during the write strobe cycle
    assign DATA = WRITE ? wdata_q : 32'bz;

`ifdef MEM_ACC_STATS_EN
    // Saturating completion counters, bumped on the edge entering ACK
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            RD_CNT <= '0;
            WR_CNT <= '0;
        end else begin
            if (capture && (RD_CNT != '1)) begin
                RD_CNT <= RD_CNT + 16'd1;
            end
            if ((state_q == S_WR) && (WR_CNT != '1)) begin
                WR_CNT <= WR_CNT + 16'd1;
            end
        end
    end
`else
    assign RD_CNT = '0;
    assign WR_CNT = '0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: transaction-timeline reference model with
// a per-cycle compare process, plus directed literal checks.
module tb_mem_access_ctrl;
    localparam int unsigned RDW = 3;

    logic        CLK;
    logic        RST;
    logic        READ, WRITE;
    logic [25:0] ADDR;
    wire  [31:0] DATA;
    logic [15:0] RD_CNT, WR_CNT;

    mem_access_ctrl_if req_bus();

    mem_access_ctrl #(.RD_WAIT(RDW)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .req_bus(req_bus),
        .READ   (READ),
        .WRITE  (WRITE),
        .ADDR   (ADDR),
        .DATA   (DATA),
        .RD_CNT (RD_CNT),
        .WR_CNT (WR_CNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- memory device model (64 words, low address bits) ----
    logic [31:0] phys [64];
    logic [31:0] idle_pat;
    logic        pl_en;
    logic [5:0]  pl_addr;
    logic [31:0] pl_data;

    assign DATA = WRITE ? 32'bz : (READ ? phys[ADDR[5:0]] : idle_pat);

    always @(posedge CLK) begin
        if (pl_en) phys[pl_addr] <= pl_data;
        else if (WRITE) phys[ADDR[5:0]] <= DATA;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          cyc = 0;
    bit          have = 0;
    int          acc = 0;
    int          len = 1;
    bit          m_rd = 0;
    logic [25:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rdata = '0;
    logic [31:0] ref_mem [64];
    int          m_rcnt = 0;
    int          m_wcnt = 0;

    always @(posedge CLK) begin
        int  d;
        bit  e_busy, e_read, e_write, e_ack;
        cyc++;
        if (pl_en) ref_mem[pl_addr] = pl_data;
        if (!RST) begin
            have = 0; m_addr = '0; m_rdata = '0; m_rcnt = 0; m_wcnt = 0;
        end else begin
            if (have && !m_rd && (cyc - acc) == 1) ref_mem[m_addr[5:0]] = m_wdata;
            if (!have || (cyc - acc) >= len + 2) begin
                if (req_bus.REQ) begin
                    have    = 1;
                    acc     = cyc;
                    m_rd    = !req_bus.REQ_WE;
                    len     = m_rd ? int'(RDW) + 1 : 1;
                    m_addr  = req_bus.REQ_ADDR;
                    m_wdata = req_bus.REQ_WDATA;
                end
            end
            if (have && (cyc - acc) == len) begin
                if (m_rd) begin
                    m_rdata = ref_mem[m_addr[5:0]];
                    if (m_rcnt < 65535) m_rcnt++;
                end else begin
                    if (m_wcnt < 65535) m_wcnt++;
                end
            end
        end
        d       = cyc - acc;
        e_busy  = have && d <= len;
        e_read  = have && m_rd && d < len;
        e_write = have && !m_rd && d < len;
        e_ack   = have && d == len;
        #1;
        chk("READ", READ, e_read);
        chk("WRITE", WRITE, e_write);
        chk("ACK", req_bus.ACK, e_ack);
        chk("BUSY", req_bus.BUSY, e_busy);
        chk("ADDR", ADDR, m_addr);
        chk("RDATA", req_bus.RDATA, m_rdata);
        chk("rd_wr_excl", READ & WRITE, 0);
        if (e_write) chk("DATA_wr", DATA, m_wdata);
        else         chk("DATA_bus", DATA, e_read ? phys[m_addr[5:0]] : idle_pat);
`ifdef MEM_ACC_STATS_EN
        chk("RD_CNT", RD_CNT, m_rcnt);
        chk("WR_CNT", WR_CNT, m_wcnt);
`else
        chk("RD_CNT", RD_CNT, 0);
        chk("WR_CNT", WR_CNT, 0);
`endif
    end

    // ---------------- stimulus ----------------
    // Caller is at a negedge with the controller idle; returns idle at a negedge.
    task automatic txn(input bit we, input logic [25:0] a, input logic [31:0] wd,
                       output int lat, output int rd_hi);
        req_bus.REQ       = 1'b1;
        req_bus.REQ_WE    = we;
        req_bus.REQ_ADDR  = a;
        req_bus.REQ_WDATA = wd;
        @(negedge CLK);
        req_bus.REQ = 1'b0;
        lat = 0;
        rd_hi = 0;
        while (!req_bus.ACK && lat < 40) begin
            rd_hi += int'(READ);
            @(negedge CLK);
            lat++;
        end
        chk("ack_seen", req_bus.ACK, 1);
        @(negedge CLK);
    endtask

    initial begin
        int lat, hi;
        int ackq[$];
        RST = 1'b0;
        req_bus.REQ = 1'b0; req_bus.REQ_WE = 1'b0;
        req_bus.REQ_ADDR = '0; req_bus.REQ_WDATA = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        idle_pat = 32'hC3C3_3C3C;

        @(negedge CLK);
        #1;
        chk("rst_BUSY", req_bus.BUSY, 0);
        chk("rst_READ", READ, 0);
        chk("rst_ADDR", ADDR, 0);
        chk("rst_RDATA", req_bus.RDATA, 0);

        for (int i = 0; i < 64; i++) begin
            pl_en   = 1'b1;
            pl_addr = 6'(i);
            pl_data = (i == 4) ? 32'h1234_5678 : 32'h1000_0000 + 32'(i) * 32'h0101;
            @(negedge CLK);
        end
        pl_en = 1'b0;

        // first accept on the first edge with reset released
        RST = 1'b1;
        txn(1'b1, 26'h10, 32'hDEAD_BEEF, lat, hi);
        chk("wr_lat", lat, 1);
        txn(1'b0, 26'h10, 32'h0, lat, hi);
        chk("rd_lat", lat, 4);
        chk("rd_read_cycles", hi, 4);
        chk("rd_data", req_bus.RDATA, 32'hDEAD_BEEF);
        txn(1'b0, 26'h4, 32'h0, lat, hi);
        chk("rd_preload", req_bus.RDATA, 32'h1234_5678);

        // REQ held high for writes: one accept every 3 cycles
        req_bus.REQ = 1'b1;
        req_bus.REQ_WE = 1'b1;
        for (int j = 1; j <= 15; j++) begin
            req_bus.REQ_ADDR  = 26'(20 + j);
            req_bus.REQ_WDATA = $urandom;
            @(negedge CLK);
            if (req_bus.ACK) begin
                ackq.push_back(j);
                chk("ack_write_low", WRITE, 0);
            end
        end
        req_bus.REQ = 1'b0;
        @(negedge CLK);
        chk("b2b_count", ackq.size(), 5);
        for (int i = 1; i < ackq.size(); i++) chk("b2b_gap", ackq[i] - ackq[i-1], 3);

        // reset mid-read aborts immediately
        req_bus.REQ = 1'b1; req_bus.REQ_WE = 1'b0; req_bus.REQ_ADDR = 26'h4;
        @(negedge CLK);
        req_bus.REQ = 1'b0;
        @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("abort_READ", READ, 0);
        chk("abort_BUSY", req_bus.BUSY, 0);
        chk("abort_ACK", req_bus.ACK, 0);
        chk("abort_RDATA", req_bus.RDATA, 0);
        @(negedge CLK);
        RST = 1'b1;
        txn(1'b0, 26'h10, 32'h0, lat, hi);
        chk("post_rst_lat", lat, 4);
        chk("post_rst_data", req_bus.RDATA, 32'hDEAD_BEEF);

        // statistics: 3 writes then 2 reads, counting from zero after reset
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        txn(1'b1, 26'h30, 32'hAAAA_0001, lat, hi);
        txn(1'b1, 26'h31, 32'hAAAA_0002, lat, hi);
        txn(1'b1, 26'h32, 32'hAAAA_0003, lat, hi);
        txn(1'b0, 26'h30, 32'h0, lat, hi);
        chk("stat_rd_30", req_bus.RDATA, 32'hAAAA_0001);
        txn(1'b0, 26'h32, 32'h0, lat, hi);
        chk("stat_rd_32", req_bus.RDATA, 32'hAAAA_0003);
`ifdef MEM_ACC_STATS_EN
        chk("stat_WR_CNT", WR_CNT, 3);
        chk("stat_RD_CNT", RD_CNT, 2);
`else
        chk("stat_WR_CNT", WR_CNT, 0);
        chk("stat_RD_CNT", RD_CNT, 0);
`endif

        // randomized traffic with occasional reset pulses
        for (int k = 0; k < 500; k++) begin
            req_bus.REQ       = 1'($urandom_range(0, 1));
            req_bus.REQ_WE    = 1'($urandom_range(0, 1));
            req_bus.REQ_ADDR  = {20'($urandom), 6'($urandom)};
            req_bus.REQ_WDATA = $urandom;
            idle_pat          = $urandom;
            RST               = ($urandom_range(0, 99) != 0);
            @(negedge CLK);
        end
        req_bus.REQ = 1'b0;
        RST = 1'b1;
        repeat (10) @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
